// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU, the result stage and the
// register-file write port.
interface alu_result_stage_if #(
    parameter int WIDTH = 16,
    parameter int REGW  = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic [REGW-1:0]  in_dest;
    logic             in_ld_reg;
    logic             in_ld_cc;
    logic             in_is_br;
    logic [2:0]       in_nzp_test;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [REGW-1:0]  out_dest;
    logic             out_ld_reg;
    logic [2:0]       nzp;
    logic             br_taken;

    modport master (
        output in_valid, in_result, in_dest,
        output in_ld_reg, in_ld_cc, in_is_br,
        output in_nzp_test, out_ready,
        input  in_ready, out_valid, out_result,
        input  out_dest, out_ld_reg, nzp, br_taken
    );

    modport slave (
        input  in_valid, in_result, in_dest,
        input  in_ld_reg, in_ld_cc, in_is_br,
        input  in_nzp_test, out_ready,
        output in_ready, out_valid, out_result,
        output out_dest, out_ld_reg, nzp, br_taken
    );
endinterface

// File: rtl/alu_result_stage.sv
// LC-3b ALU result stage: 2-entry elastic buffer, in-order retire,
// NZP condition-code register and branch evaluation at retire.
module alu_result_stage #(
    parameter int WIDTH = 16,
    parameter int REGW  = 3
) (
    input logic              clk,
    input logic              rst_n,
    input logic              flush,
    alu_result_stage_if.slave bus
);
    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [REGW-1:0]  dest;
        logic             ld_reg;
        logic             ld_cc;
        logic             is_br;
        logic [2:0]       nzp_test;
    } entry_t;

    entry_t     mem [2];
    entry_t     in_e;
    entry_t     hd;
    logic       head;
    logic       tail;
    logic [1:0] count;
    logic [1:0] count_nx;
    logic [2:0] nzp_q;
    logic [2:0] cc;
    logic       br_q;
    logic       push;
    logic       pop;
    logic       n_bit;
    logic       z_bit;

    // Branches never write back, whatever tags arrived with them.
    always_comb begin
        in_e          = '0;
        in_e.result   = bus.in_result;
        in_e.dest     = bus.in_dest;
        in_e.ld_reg   = bus.in_ld_reg & ~bus.in_is_br;
        in_e.ld_cc    = bus.in_ld_cc & ~bus.in_is_br;
        in_e.is_br    = bus.in_is_br;
        in_e.nzp_test = bus.in_nzp_test;
    end

    assign hd   = mem[head];
    assign push = bus.in_valid & bus.in_ready & ~flush;
    assign pop  = bus.out_valid & bus.out_ready & ~flush;

    assign n_bit = hd.result[WIDTH-1];
    assign z_bit = (hd.result == '0);
    assign cc    = {n_bit, z_bit, ~n_bit & ~z_bit};

    always_comb begin
        count_nx = count;
        unique case ({push, pop})
            2'b10:   count_nx = count + 2'd1;
            2'b01:   count_nx = count - 2'd1;
            default: count_nx = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            head   <= 1'b0;
            tail   <= 1'b0;
            count  <= 2'd0;
            nzp_q  <= 3'b010;
            br_q   <= 1'b0;
        end else if (flush) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
            br_q  <= 1'b0;
        end else begin
            if (push) begin
                mem[tail] <= in_e;
                tail      <= ~tail;
            end
            if (pop) head <= ~head;
            count <= count_nx;
            // Branch sees the codes from before this edge's update.
            br_q <= pop & hd.is_br & |(hd.nzp_test & nzp_q);
            if (pop && hd.ld_cc) nzp_q <= cc;
        end
    end

    assign bus.in_ready   = (count != 2'd2);
    assign bus.out_valid  = (count != 2'd0);
    assign bus.out_result = hd.result;
    assign bus.out_dest   = hd.dest;
    assign bus.out_ld_reg = hd.ld_reg;
    assign bus.nzp        = nzp_q;
    assign bus.br_taken   = br_q;
endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: directed scenarios plus
// random traffic against a queue-based reference model.
module tb_alu_result_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    alu_result_stage_if #(.WIDTH(16), .REGW(3)) bus ();

    alu_result_stage #(.WIDTH(16), .REGW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] r;
        logic [2:0]  d;
        logic        lr;
        logic        lc;
        logic        br;
        logic [2:0]  t;
    } exp_t;

    exp_t       q[$];
    logic [2:0] m_nzp = 3'b010;
    logic       m_br = 1'b0;
    int         tests = 0;
    int         fails = 0;
    int         taken_seen = 0;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] cc_of(input logic [15:0] r);
        if ($signed(r) < 0) return 3'b100;
        if (r == 16'd0) return 3'b010;
        return 3'b001;
    endfunction

    always @(negedge rst_n) begin
        q.delete();
        m_nzp = 3'b010;
        m_br  = 1'b0;
    end

    // Monitor: compares retiring entries and architectural state.
    always @(negedge clk) begin : mon
        exp_t e;
        exp_t a;
        if (rst_n) begin
            check("in_ready", bus.in_ready, q.size() != 2);
            check("out_valid", bus.out_valid, q.size() != 0);
            check("nzp", bus.nzp, m_nzp);
            check("br_taken", bus.br_taken, m_br);
            if (bus.br_taken) taken_seen++;
            if (flush) begin
                q.delete();
                m_br = 1'b0;
            end else begin
                m_br = 1'b0;
                if (bus.out_valid && bus.out_ready
                    && q.size() > 0) begin
                    e = q.pop_front();
                    check("out_result", bus.out_result, e.r);
                    check("out_dest", bus.out_dest, e.d);
                    check("out_ld_reg", bus.out_ld_reg,
                          e.lr && !e.br);
                    if (e.br) m_br = |(e.t & m_nzp);
                    if (e.lc && !e.br) m_nzp = cc_of(e.r);
                end
                if (bus.in_valid && bus.in_ready) begin
                    a.r  = bus.in_result;
                    a.d  = bus.in_dest;
                    a.lr = bus.in_ld_reg;
                    a.lc = bus.in_ld_cc;
                    a.br = bus.in_is_br;
                    a.t  = bus.in_nzp_test;
                    q.push_back(a);
                end
            end
        end
    end

    task automatic idle_inputs();
        bus.in_valid    = 1'b0;
        bus.in_result   = '0;
        bus.in_dest     = '0;
        bus.in_ld_reg   = 1'b0;
        bus.in_ld_cc    = 1'b0;
        bus.in_is_br    = 1'b0;
        bus.in_nzp_test = '0;
    endtask

    // Called just after a rising edge; returns just after the
    // edge that accepted the entry.
    task automatic push(input logic [15:0] r, input logic [2:0] d,
                        input logic lr, input logic lc,
                        input logic br, input logic [2:0] t);
        int n;
        bus.in_valid    = 1'b1;
        bus.in_result   = r;
        bus.in_dest     = d;
        bus.in_ld_reg   = lr;
        bus.in_ld_cc    = lc;
        bus.in_is_br    = br;
        bus.in_nzp_test = t;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("push_timeout", 1, 0);
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        bus.out_ready = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_nzp", bus.nzp, 3'b010);
        check("rst_br", bus.br_taken, 0);
        check("rst_in_ready", bus.in_ready, 1);
        cycles(1);

        // Stream with ready held high.
        bus.out_ready = 1'b1;
        push(16'h0005, 3'd1, 1'b1, 1'b1, 1'b0, 3'b000);
        check("stream_lat", bus.out_valid, 1);
        check("stream_head", bus.out_result, 16'h0005);
        push(16'h8000, 3'd2, 1'b1, 1'b1, 1'b0, 3'b000);
        check("stream_nzp_a", bus.nzp, 3'b001);
        check("stream_head_b", bus.out_result, 16'h8000);
        push(16'h0000, 3'd3, 1'b1, 1'b1, 1'b0, 3'b000);
        check("stream_nzp_b", bus.nzp, 3'b100);
        cycles(2);
        check("stream_nzp_c", bus.nzp, 3'b010);

        // Backpressure: third entry is held by the sender.
        bus.out_ready = 1'b0;
        push(16'h00a1, 3'd4, 1'b1, 1'b0, 1'b0, 3'b000);
        push(16'h00b2, 3'd5, 1'b1, 1'b0, 1'b0, 3'b000);
        fork
            push(16'h00c3, 3'd6, 1'b0, 1'b0, 1'b0, 3'b000);
            begin
                cycles(1);
                check("bp_in_ready", bus.in_ready, 0);
                check("bp_head", bus.out_result, 16'h00a1);
                bus.out_ready = 1'b1;
            end
        join
        cycles(3);

        // Branch evaluated against nzp=100.
        push(16'hfff0, 3'd0, 1'b0, 1'b1, 1'b0, 3'b000);
        push(16'h1234, 3'd7, 1'b1, 1'b1, 1'b1, 3'b100);
        push(16'h0000, 3'd7, 1'b1, 1'b1, 1'b1, 3'b011);
        cycles(3);
        check("br_nzp_kept", bus.nzp, 3'b100);

        // CC update immediately followed by BR z.
        push(16'h0000, 3'd1, 1'b1, 1'b1, 1'b0, 3'b000);
        push(16'h0000, 3'd0, 1'b0, 1'b0, 1'b1, 3'b010);
        cycles(3);
        check("cc_br_taken_seen", taken_seen, 2);

        // Flush with two entries plus simultaneous push/pop.
        bus.out_ready = 1'b0;
        push(16'h8000, 3'd2, 1'b1, 1'b1, 1'b0, 3'b000);
        push(16'h0000, 3'd3, 1'b0, 1'b0, 1'b1, 3'b111);
        bus.in_valid  = 1'b1;
        bus.in_result = 16'h0042;
        bus.out_ready = 1'b1;
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        idle_inputs();
        check("flush_valid", bus.out_valid, 0);
        check("flush_nzp", bus.nzp, 3'b010);
        check("flush_br", bus.br_taken, 0);
        cycles(2);

        // Reset mid-traffic, checked before any clock edge.
        bus.out_ready = 1'b0;
        push(16'h7777, 3'd4, 1'b1, 1'b1, 1'b0, 3'b000);
        push(16'h8888, 3'd5, 1'b1, 1'b1, 1'b0, 3'b000);
        bus.out_ready = 1'b1;
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_nzp", bus.nzp, 3'b010);
        check("mid_rst_br", bus.br_taken, 0);
        check("mid_rst_ready", bus.in_ready, 1);
        cycles(2);
        rst_n = 1'b1;
        cycles(2);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       bus.in_result = 16'h0000;
                1:       bus.in_result = 16'h8000 |
                                         16'($urandom);
                default: bus.in_result = 16'($urandom);
            endcase
            bus.in_dest     = 3'($urandom);
            bus.in_ld_reg   = 1'($urandom);
            bus.in_ld_cc    = 1'($urandom);
            bus.in_is_br    = ($urandom_range(0, 3) == 0);
            bus.in_nzp_test = 3'($urandom);
            bus.out_ready   = ($urandom_range(0, 9) < 7);
            flush           = ($urandom_range(0, 39) == 0);
            cycles(1);
        end
        flush = 1'b0;
        idle_inputs();
        bus.out_ready = 1'b1;
        cycles(5);
        check("drain_empty", bus.out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
